// File: rtl/if_mem_ctrl.sv
// Instruction-fetch memory controller: owns the fetch PC and issues one word read at a time.
// It hands {pc, inst} to stage_1, and it handles stalls, late redirects and stale responses.
module if_mem_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc_next,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic        o_valid,
  output logic        o_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] out_pc_d, inst_d;
  logic        valid_d, misalign_d;
  logic        discard_q, discard_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      o_pc       <= RESET_PC;
      o_inst     <= NOP_INST;
      o_valid    <= 1'b0;
      o_misalign <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      o_pc       <= out_pc_d;
      o_inst     <= inst_d;
      o_valid    <= valid_d;
      o_misalign <= misalign_d;
      discard_q  <= discard_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    out_pc_d   = o_pc;
    inst_d     = o_inst;
    valid_d    = o_valid;
    misalign_d = o_misalign;
    discard_d  = discard_q;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (i_redirect) pc_d = i_redirect_pc;
      end
      REQ: begin
        if (i_redirect) begin
          pc_d = i_redirect_pc;
          // A request granted alongside a redirect is for the old PC; drop its response.
          if (i_mem_gnt) begin
            state_d   = WAIT;
            discard_d = 1'b1;
          end
        end else if (i_mem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (i_redirect) begin
          pc_d = i_redirect_pc;
          if (i_mem_rvalid) begin
            state_d   = REQ;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end else if (i_mem_rvalid) begin
          if (discard_q) begin
            state_d   = REQ;
            discard_d = 1'b0;
          end else begin
            inst_d   = i_mem_rdata;
            out_pc_d = pc_q;
            valid_d  = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (i_redirect || !i_stall) begin
          pc_d       = i_redirect ? i_redirect_pc : i_pc_next;
          valid_d    = 1'b0;
          misalign_d = 1'b0;
          inst_d     = NOP_INST;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // A misaligned fetch address never reaches memory; it is presented as a flagged NOP.
    if (state_d == REQ && pc_d[1:0] != 2'b00) begin
      state_d    = HOLD;
      valid_d    = 1'b1;
      misalign_d = 1'b1;
      inst_d     = NOP_INST;
      out_pc_d   = pc_d;
    end
  end

  assign o_mem_req  = (state_q == REQ);
  assign o_mem_addr = {pc_q[31:2], 2'b00};

endmodule

// File: tb/tb_if_mem_ctrl.sv
// Directed bench for if_mem_ctrl: fetch, stall, redirects, misalignment and reset mid-transaction.
module tb_if_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_next, redirect_pc, mem_rdata, mem_addr, pc, inst;
  logic        stall, redirect, mem_req, mem_gnt, mem_rvalid, valid, misalign;

  int n_vec = 0;
  int n_bad = 0;

  if_mem_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pc_next(pc_next), .i_stall(stall),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_gnt(mem_gnt),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_pc(pc), .o_inst(inst), .o_valid(valid), .o_misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; pc_next = '0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_inst", inst, 32'h13);
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    rst_n = 1'b1;

    // Zero-wait fetch at 0
    tick();
    chk("c1_req", {31'd0, mem_req}, 32'd1);
    chk("c1_addr", mem_addr, 32'h0);
    mem_gnt = 1'b1;
    tick();
    chk("c2_req", {31'd0, mem_req}, 32'd0);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0093;
    tick();
    mem_rvalid = 1'b0;
    chk("c3_valid", {31'd0, valid}, 32'd1);
    chk("c3_pc", pc, 32'h0);
    chk("c3_inst", inst, 32'h0000_0093);
    pc_next = 32'h4;
    tick();
    chk("next_req", {31'd0, mem_req}, 32'd1);
    chk("next_addr", mem_addr, 32'h4);
    chk("next_valid", {31'd0, valid}, 32'd0);
    chk("next_inst", inst, 32'h13);

    // Fetch at 4, then stall for 4 cycles in HOLD
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    mem_rvalid = 1'b0; stall = 1'b1; pc_next = 32'h8;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_valid", {31'd0, valid}, 32'd1);
      chk("stall_pc", pc, 32'h4);
      chk("stall_inst", inst, 32'h1111_1111);
      chk("stall_req", {31'd0, mem_req}, 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("rel_req", {31'd0, mem_req}, 32'd1);
    chk("rel_addr", mem_addr, 32'h8);

    // Redirect to 0x200 coincident with grant for 8
    mem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    mem_gnt = 1'b0; redirect = 1'b0;
    chk("rg_req", {31'd0, mem_req}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    mem_rvalid = 1'b0;
    chk("rg_valid", {31'd0, valid}, 32'd0);
    chk("rg_req2", {31'd0, mem_req}, 32'd1);
    chk("rg_addr", mem_addr, 32'h200);

    // Redirect to 0x100 in WAIT, stale response 2 cycles later
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("rw_req_a", {31'd0, mem_req}, 32'd0);
    tick();
    chk("rw_req_b", {31'd0, mem_req}, 32'd0);
    chk("rw_valid_b", {31'd0, valid}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    chk("rw_valid", {31'd0, valid}, 32'd0);
    chk("rw_inst", inst, 32'h13);
    chk("rw_req", {31'd0, mem_req}, 32'd1);
    chk("rw_addr", mem_addr, 32'h100);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0022;
    tick();
    mem_rvalid = 1'b0;
    chk("rw_fetch_pc", pc, 32'h100);
    chk("rw_fetch_inst", inst, 32'h22);

    // Redirect from HOLD to misaligned 0x102
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
    chk("mis_req", {31'd0, mem_req}, 32'd0);
    chk("mis_valid", {31'd0, valid}, 32'd1);
    chk("mis_flag", {31'd0, misalign}, 32'd1);
    chk("mis_inst", inst, 32'h13);
    chk("mis_pc", pc, 32'h102);
    tick();
    chk("mis_hold_req", {31'd0, mem_req}, 32'd0);
    chk("mis_hold_flag", {31'd0, misalign}, 32'd1);
    stall = 1'b0; pc_next = 32'h300;
    tick();
    chk("mis_rel_req", {31'd0, mem_req}, 32'd1);
    chk("mis_rel_addr", mem_addr, 32'h300);
    chk("mis_rel_flag", {31'd0, misalign}, 32'd0);
    chk("mis_rel_valid", {31'd0, valid}, 32'd0);

    // Reset while waiting; stale response arrives during IDLE/REQ
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("ar_req", {31'd0, mem_req}, 32'd0);
    chk("ar_addr", mem_addr, 32'h0);
    chk("ar_valid", {31'd0, valid}, 32'd0);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    tick();
    chk("ar_req1", {31'd0, mem_req}, 32'd1);
    chk("ar_addr1", mem_addr, 32'h0);
    tick();
    chk("ar_req2", {31'd0, mem_req}, 32'd1);
    chk("ar_valid2", {31'd0, valid}, 32'd0);
    mem_rvalid = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0033;
    tick();
    mem_rvalid = 1'b0;
    chk("ar_fetch_valid", {31'd0, valid}, 32'd1);
    chk("ar_fetch_pc", pc, 32'h0);
    chk("ar_fetch_inst", inst, 32'h33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
